flex_pts_frame_tx: RTL and testbench



---
 rtl/flex_pts_frame_tx.sv | 153 +++++++++++++++
 tb/tb_flex_pts_frame_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/flex_pts_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit (0), NUM_BITS data bits, stop bit (1).
// Each bit is held for BIT_PERIOD clocks. The idle line is 1.
module flex_pts_frame_tx #(
   parameter int NUM_BITS   = 8,
   parameter int SHIFT_MSB  = 1,
   parameter int BIT_PERIOD = 10
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic                serial_out,
   output logic                tx_busy,
   output logic                frame_done
);

   // A one-clock bit period still needs a 1-bit counter that simply stays at 0
   localparam int PER_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int BIT_W = $clog2(NUM_BITS + 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(BIT_PERIOD - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_BITS-1:0] r_shift;
   logic [NUM_BITS-1:0] w_shift_nxt;
   logic [PER_W-1:0]    r_per_cnt;
   logic [PER_W-1:0]    w_per_cnt_nxt;
   logic [BIT_W-1:0]    r_bit_cnt;
   logic [BIT_W-1:0]    w_bit_cnt_nxt;
   logic                r_serial;
   logic                w_serial_nxt;
   logic                r_done;
   logic                w_done_nxt;

   logic                w_accept;
   logic                w_per_end;
   logic                w_head;
   logic [NUM_BITS-1:0] w_shifted;

   assign w_accept  = tx_valid && (r_state == S_IDLE);
   assign w_per_end = (r_per_cnt == PER_LAST);

   // Vacated positions fill with 1 so the register drains to the idle level
   generate
      if (SHIFT_MSB != 0) begin : g_msb_first
         assign w_head    = r_shift[NUM_BITS-1];
         assign w_shifted = {r_shift[NUM_BITS-2:0], 1'b1};
      end else begin : g_lsb_first
         assign w_head    = r_shift[0];
         assign w_shifted = {1'b1, r_shift[NUM_BITS-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         r_shift   <= '1;
         r_per_cnt <= '0;
         r_bit_cnt <= '0;
         r_serial  <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_per_cnt <= w_per_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_serial  <= w_serial_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_per_cnt_nxt = r_per_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
      w_serial_nxt  = r_serial;
      w_done_nxt    = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_serial_nxt = 1'b1;
            if (w_accept) begin
               w_state_nxt   = S_START;
               w_shift_nxt   = tx_data;
               w_per_cnt_nxt = '0;
               w_bit_cnt_nxt = '0;
               w_serial_nxt  = 1'b0;
            end
         end

         S_START: begin
            if (w_per_end) begin
               w_state_nxt   = S_DATA;
               w_serial_nxt  = w_head;
               w_shift_nxt   = w_shifted;
               w_per_cnt_nxt = '0;
               w_bit_cnt_nxt = '0;
            end else begin
               w_per_cnt_nxt = r_per_cnt + 1'b1;
            end
         end

         // r_bit_cnt indexes the data bit currently on the line
         S_DATA: begin
            if (w_per_end) begin
               w_per_cnt_nxt = '0;
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_nxt  = S_STOP;
                  w_serial_nxt = 1'b1;
               end else begin
                  w_serial_nxt  = w_head;
                  w_shift_nxt   = w_shifted;
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               end
            end else begin
               w_per_cnt_nxt = r_per_cnt + 1'b1;
            end
         end

         S_STOP: begin
            if (w_per_end) begin
               w_state_nxt   = S_IDLE;
               w_serial_nxt  = 1'b1;
               w_done_nxt    = 1'b1;
               w_per_cnt_nxt = '0;
            end else begin
               w_per_cnt_nxt = r_per_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt  = S_IDLE;
            w_serial_nxt = 1'b1;
         end
      endcase
   end

   assign tx_ready   = (r_state == S_IDLE);
   assign tx_busy    = (r_state != S_IDLE);
   assign serial_out = r_serial;
   assign frame_done = r_done;

endmodule

// File: tb/tb_flex_pts_frame_tx.sv
// Scoreboard bench for flex_pts_frame_tx: three configurations share clock and reset;
// expected per-cycle line/busy/done values are queued at acceptance and popped by a monitor.
module tb_flex_pts_frame_tx;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [7:0] tx_data    [3];
   logic       tx_valid   [3];
   logic       tx_ready   [3];
   logic       serial_out [3];
   logic       tx_busy    [3];
   logic       frame_done [3];

   always #5 clk = ~clk;

   // d0: MSB first, 4 clk/bit; d1: LSB first, 4 clk/bit; d2: 4-bit word, 1 clk/bit
   flex_pts_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .BIT_PERIOD(4)) u_d0 (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .serial_out(serial_out[0]), .tx_busy(tx_busy[0]),
      .frame_done(frame_done[0]));

   flex_pts_frame_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .BIT_PERIOD(4)) u_d1 (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .serial_out(serial_out[1]), .tx_busy(tx_busy[1]),
      .frame_done(frame_done[1]));

   flex_pts_frame_tx #(.NUM_BITS(4), .SHIFT_MSB(1), .BIT_PERIOD(1)) u_d2 (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data[2][3:0]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .serial_out(serial_out[2]), .tx_busy(tx_busy[2]),
      .frame_done(frame_done[2]));

   typedef struct {
      int         dut;
      logic [2:0] v;   // {serial_out, tx_busy, frame_done}
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   last_done_cyc [3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every cycle a DUT shows busy or done, one queued expectation is consumed
   always @(negedge clk) begin
      if (n_rst === 1'b1) begin
         for (int d = 0; d < 3; d++) begin
            if (tx_busy[d] || frame_done[d]) begin
               if (sb.size() == 0) begin
                  chk($sformatf("unexpected_output_d%0d", d), 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("dut_id", d, e.dut);
                  chk($sformatf("line_busy_done_d%0d", d),
                      int'({serial_out[d], tx_busy[d], frame_done[d]}), int'(e.v));
                  if (frame_done[d]) last_done_cyc[d] = cyc;
               end
            end
         end
      end
   end

   // seq holds the line bits in transmit order, first bit at seq[nb-1]
   task automatic push_frame(input int d, input logic [9:0] seq, input int nb, input int bp);
      exp_t e;
      e.dut = d;
      for (int k = nb - 1; k >= 0; k--) begin
         for (int j = 0; j < bp; j++) begin
            e.v = {seq[k], 2'b10};
            sb.push_back(e);
         end
      end
      e.v = 3'b101;
      sb.push_back(e);
   endtask

   task automatic wait_accept(input int d, input logic [9:0] seq, input int nb, input int bp,
                              input bit keep, output int e0);
      bit got = 1'b0;
      e0 = -1;
      for (int i = 0; i < 200 && !got; i++) begin
         if (tx_ready[d]) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!got) begin
         chk($sformatf("accept_timeout_d%0d", d), 0, 1);
      end else begin
         e0 = cyc;
         push_frame(d, seq, nb, bp);
      end
      if (!keep) tx_valid[d] = 1'b0;
   endtask

   task automatic send(input int d, input logic [7:0] data, input logic [9:0] seq,
                       input int nb, input int bp, input bit keep, output int e0);
      @(negedge clk);
      tx_data[d]  = data;
      tx_valid[d] = 1'b1;
      wait_accept(d, seq, nb, bp, keep, e0);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk(name, sb.size(), 0);
   endtask

   initial begin
      int e0a;
      int e0b;
      for (int d = 0; d < 3; d++) begin
         tx_data[d]  = 8'h00;
         tx_valid[d] = 1'b0;
         last_done_cyc[d] = -1;
      end

      // Reset then idle
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         chk($sformatf("reset_state_d%0d", d),
             int'({serial_out[d], tx_ready[d], tx_busy[d], frame_done[d]}), 'b1100);
      @(negedge clk);
      n_rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++)
            chk($sformatf("idle_d%0d", d),
                int'({serial_out[d], tx_ready[d], tx_busy[d], frame_done[d]}), 'b1100);
      end

      // MSB-first 0xC1: 0, 1,1,0,0,0,0,0,1, 1
      send(0, 8'hC1, 10'b0110000011, 10, 4, 1'b0, e0a);
      drain("drain_msb_c1");
      chk("done_latency_msb", last_done_cyc[0] - e0a, 40);

      // LSB-first 0xC1: 0, 1,0,0,0,0,0,1,1, 1
      send(1, 8'hC1, 10'b0100000111, 10, 4, 1'b0, e0a);
      drain("drain_lsb_c1");
      chk("done_latency_lsb", last_done_cyc[1] - e0a, 40);

      // Back-to-back 0x5A then 0xFF with tx_valid held and tx_data changing mid-frame
      send(0, 8'h5A, 10'b0010110101, 10, 4, 1'b1, e0a);
      repeat (10) @(negedge clk);
      tx_data[0] = 8'hA5;
      repeat (20) @(negedge clk);
      tx_data[0] = 8'hFF;
      wait_accept(0, 10'b0111111111, 10, 4, 1'b0, e0b);
      chk("b2b_e0_spacing", e0b - e0a, 41);
      drain("drain_b2b");

      // Reset during the third data bit of 0xC1 (line is 0 there)
      send(0, 8'hC1, 10'b0110000011, 10, 4, 1'b0, e0a);
      repeat (13) @(posedge clk);
      #2;
      chk("line_before_reset", int'(serial_out[0]), 0);
      n_rst = 1'b0;
      #1;
      chk("async_reset_state",
          int'({serial_out[0], tx_ready[0], tx_busy[0], frame_done[0]}), 'b1100);
      sb.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (50) @(negedge clk);
      chk("no_done_after_abort", int'(frame_done[0]), 0);
      send(0, 8'h01, 10'b0000000011, 10, 4, 1'b0, e0a);
      drain("drain_after_reset");
      chk("done_latency_after_reset", last_done_cyc[0] - e0a, 40);

      // One clock per bit, 4-bit 0x9: 0,1,0,0,1,1
      send(2, 8'h09, 10'b0000010011, 6, 1, 1'b0, e0a);
      drain("drain_bp1");
      chk("done_latency_bp1", last_done_cyc[2] - e0a, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
